// File: rtl/arp_reply_tx_pkg.sv
// arp_reply_tx_pkg: shared ARP/Ethernet constants, TX state encodings and the
// latched-field record used by the ARP reply transmitter.
//
// Build option: ARP_TX_PAD_EN. When defined, the frame is padded with zeros
// to the 60-byte Ethernet minimum. Otherwise it is 42 bytes and the MAC pads.
package arp_reply_tx_pkg;

  localparam logic [47:0] BRDCAST_DEST_ADDR = 48'hFFFF_FFFF_FFFF;
  localparam logic [15:0] ARP_FRAME_TYPE    = 16'h0806;
  localparam logic [15:0] ETH_HW_TYPE       = 16'h0001;
  localparam logic [15:0] IP_PROT_TYPE      = 16'h0800;
  localparam logic [7:0]  ETH_HW_LEN        = 8'h06;
  localparam logic [7:0]  IP_PROT_LEN       = 8'h04;

  localparam logic [15:0] REPLY_ARP_OP      = 16'h0002;
  localparam int          ARP_FRAME_LEN     = 42;
  localparam int          ETH_MIN_FRAME_LEN = 60;

`ifdef ARP_TX_PAD_EN
  localparam int FRAME_LEN = ETH_MIN_FRAME_LEN;
`else
  localparam int FRAME_LEN = ARP_FRAME_LEN;
`endif

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_FRAME = 2'd1,
    TX_GAP   = 2'd2
  } tx_state_e;

  // Fields captured at request acceptance; held for the whole frame.
  typedef struct packed {
    logic [47:0] my_mac;
    logic [31:0] my_ip;
    logic [47:0] dest_mac;
    logic [31:0] dest_ip;
  } arp_fields_t;

endpackage

// File: rtl/arp_reply_byte_mux.sv
// arp_reply_byte_mux: combinational map from byte index to ARP reply byte.
//   idx_i    : byte index within the frame (0..63)
//   fields_i : latched MAC/IP fields
//   byte_o   : frame byte at idx_i; 0x00 for idx_i >= 42 (padding region)
module arp_reply_byte_mux
  import arp_reply_tx_pkg::*;
(
  input  logic [5:0]  idx_i,
  input  arp_fields_t fields_i,
  output logic [7:0]  byte_o
);

  // Whole 42-byte reply laid out MSB-first; byte 0 sits in the top octet.
  logic [ARP_FRAME_LEN*8-1:0] frame;
  logic [5:0]                 rev;

  assign frame = {fields_i.dest_mac, fields_i.my_mac, ARP_FRAME_TYPE,
                  ETH_HW_TYPE, IP_PROT_TYPE, ETH_HW_LEN, IP_PROT_LEN,
                  REPLY_ARP_OP, fields_i.my_mac, fields_i.my_ip,
                  fields_i.dest_mac, fields_i.dest_ip};

  always_comb begin
    byte_o = 8'h00;
    rev    = 6'(ARP_FRAME_LEN - 1) - idx_i;
    if (idx_i < 6'(ARP_FRAME_LEN))
      byte_o = frame[{rev, 3'b000} +: 8];
  end

endmodule

// File: rtl/arp_reply_tx.sv
// arp_reply_tx: serialises an Ethernet II ARP reply onto an 8-bit
// valid/ready byte stream after a one-cycle request pulse.
//   clk, areset          : clock, synchronous active-high reset
//   my_mac, my_ip        : local addresses, sampled at acceptance
//   arp_send             : request pulse, accepted only when idle
//   dest_mac, dest_ip    : requester addresses, sampled with arp_send
//   tx_ready             : downstream accepts current byte
//   tx_valid/data/last   : byte stream out (registered)
//   busy                 : not idle
//   req_dropped          : pulse when a request arrives while busy
// Build option: ARP_TX_PAD_EN (pad frame to 60 bytes, see package).
module arp_reply_tx
  import arp_reply_tx_pkg::*;
#(
  parameter int IFG_CYCLES = 12
) (
  input  logic        clk,
  input  logic        areset,
  input  logic [47:0] my_mac,
  input  logic [31:0] my_ip,
  input  logic        arp_send,
  input  logic [47:0] dest_mac,
  input  logic [31:0] dest_ip,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_last,
  output logic        busy,
  output logic        req_dropped
);

  localparam int             GAP_W    = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [5:0]     LAST_IDX = 6'(FRAME_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = (IFG_CYCLES > 0) ? GAP_W'(IFG_CYCLES - 1) : '0;

  tx_state_e        state_q, state_d;
  logic [5:0]       idx_q, idx_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  arp_fields_t      fields_q, fields_d;
  logic             drop_d;
  logic [7:0]       mux_byte;

  logic             tx_valid_q, tx_last_q, busy_q, drop_q;
  logic [7:0]       tx_data_q;

  // Mux is driven by next-state values so the output byte is registered
  // alongside the index that selects it; stalls hold idx, so data holds.
  arp_reply_byte_mux u_mux (
    .idx_i    (idx_d),
    .fields_i (fields_d),
    .byte_o   (mux_byte)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    gap_d    = gap_q;
    fields_d = fields_q;
    drop_d   = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        idx_d = '0;
        gap_d = '0;
        if (arp_send) begin
          fields_d.my_mac   = my_mac;
          fields_d.my_ip    = my_ip;
          fields_d.dest_mac = dest_mac;
          fields_d.dest_ip  = dest_ip;
          state_d           = TX_FRAME;
        end
      end
      TX_FRAME: begin
        drop_d = arp_send;
        if (tx_valid_q && tx_ready) begin
          if (idx_q == LAST_IDX)
            state_d = (IFG_CYCLES == 0) ? TX_IDLE : TX_GAP;
          else
            idx_d = idx_q + 6'd1;
        end
      end
      TX_GAP: begin
        drop_d = arp_send;
        gap_d  = gap_q + GAP_W'(1);
        if (gap_q == GAP_LAST)
          state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      state_q    <= TX_IDLE;
      idx_q      <= '0;
      gap_q      <= '0;
      fields_q   <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      fields_q   <= fields_d;
      tx_valid_q <= (state_d == TX_FRAME);
      tx_data_q  <= (state_d == TX_FRAME) ? mux_byte : 8'h00;
      tx_last_q  <= (state_d == TX_FRAME) && (idx_d == LAST_IDX);
      busy_q     <= (state_d != TX_IDLE);
      drop_q     <= drop_d;
    end
  end

  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign tx_last     = tx_last_q;
  assign busy        = busy_q;
  assign req_dropped = drop_q;

endmodule
